// File: rtl/uart_matrix_loader.sv
// uart_matrix_loader: UART receiver that loads 12-bit words into data memory.
// Each 3-byte packet {addr[11:4]}, {addr[3:0], data[11:8]}, {data[7:0]}
// produces one single-cycle write on the memory write port.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   rx         UART serial input, idle high, asynchronous to clk
//   write_en   one-cycle write strobe
//   addr       12-bit write address (held between writes)
//   datain     N-bit write data, payload in [11:0], upper bits zero
//   busy       high while a packet is in flight or its write is pending
//   frame_err  one-cycle pulse on glitch start, stop-bit error, timeout
//              (and parity error when enabled)
//   word_count completed writes since reset, saturating at 4096
//
// Optional feature: define UART_LOADER_PARITY_EN for 8E1 framing with an
// even-parity check; the default build is 8N1.
module uart_matrix_loader #(
  parameter int unsigned N              = 17,
  parameter int unsigned CLKS_PER_BIT   = 434,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rx,
  output logic          write_en,
  output logic [11:0]   addr,
  output logic [N-1:0]  datain,
  output logic          busy,
  output logic          frame_err,
  output logic [12:0]   word_count
);

  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned WC_MAX   = 4096;

`ifdef UART_LOADER_PARITY_EN
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;
`else
  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;
`endif

  typedef enum logic [1:0] {
    PK_B0, PK_B1, PK_B2, PK_WR
  } pk_state_t;

  // Synchroniser
  logic rx_meta, rx_sync;

  // Receiver state
  rx_state_t        rx_state, rx_state_nxt;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             stop_wait, stop_wait_nxt;
`ifdef UART_LOADER_PARITY_EN
  logic             par_bad, par_bad_nxt;
`endif
  logic             byte_valid_c;
  logic             rx_err_c;

  // Packet state
  pk_state_t        pk_state, pk_state_nxt;
  logic [TO_W-1:0]  to_cnt, to_cnt_nxt;
  logic [7:0]       addr_hi, addr_hi_nxt;
  logic [7:0]       mid_byte, mid_byte_nxt;
  logic             timeout_c;

  // Registered outputs
  logic             write_en_nxt;
  logic [11:0]      addr_nxt;
  logic [N-1:0]     datain_nxt;
  logic             busy_nxt;
  logic             frame_err_nxt;
  logic [12:0]      word_count_nxt;

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_state   <= RX_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      stop_wait  <= 1'b0;
`ifdef UART_LOADER_PARITY_EN
      par_bad    <= 1'b0;
`endif
      pk_state   <= PK_B0;
      to_cnt     <= '0;
      addr_hi    <= '0;
      mid_byte   <= '0;
      write_en   <= 1'b0;
      addr       <= '0;
      datain     <= '0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      word_count <= '0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_state   <= rx_state_nxt;
      clk_cnt    <= clk_cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      shift      <= shift_nxt;
      stop_wait  <= stop_wait_nxt;
`ifdef UART_LOADER_PARITY_EN
      par_bad    <= par_bad_nxt;
`endif
      pk_state   <= pk_state_nxt;
      to_cnt     <= to_cnt_nxt;
      addr_hi    <= addr_hi_nxt;
      mid_byte   <= mid_byte_nxt;
      write_en   <= write_en_nxt;
      addr       <= addr_nxt;
      datain     <= datain_nxt;
      busy       <= busy_nxt;
      frame_err  <= frame_err_nxt;
      word_count <= word_count_nxt;
    end
  end

  // Next-state and output logic for the receiver and packet assembler
  always_comb begin
    rx_state_nxt   = rx_state;
    clk_cnt_nxt    = clk_cnt;
    bit_idx_nxt    = bit_idx;
    shift_nxt      = shift;
    stop_wait_nxt  = stop_wait;
`ifdef UART_LOADER_PARITY_EN
    par_bad_nxt    = par_bad;
`endif
    byte_valid_c   = 1'b0;
    rx_err_c       = 1'b0;
    pk_state_nxt   = pk_state;
    to_cnt_nxt     = '0;
    addr_hi_nxt    = addr_hi;
    mid_byte_nxt   = mid_byte;
    timeout_c      = 1'b0;
    write_en_nxt   = 1'b0;
    addr_nxt       = addr;
    datain_nxt     = datain;
    word_count_nxt = word_count;

    // Receiver: start edge, mid-bit sampling, stop check
    case (rx_state)
      RX_IDLE: begin
        clk_cnt_nxt   = '0;
        bit_idx_nxt   = '0;
        stop_wait_nxt = 1'b0;
`ifdef UART_LOADER_PARITY_EN
        par_bad_nxt   = 1'b0;
`endif
        if (!rx_sync) rx_state_nxt = RX_START;
      end
      RX_START: begin
        if (clk_cnt == CNT_W'(HALF_BIT - 1)) begin
          clk_cnt_nxt = '0;
          if (rx_sync) begin
            rx_err_c     = 1'b1;
            rx_state_nxt = RX_IDLE;
          end else begin
            rx_state_nxt = RX_DATA;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_nxt = '0;
          shift_nxt   = {rx_sync, shift[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_LOADER_PARITY_EN
            rx_state_nxt = RX_PARITY;
`else
            rx_state_nxt = RX_STOP;
`endif
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
`ifdef UART_LOADER_PARITY_EN
      RX_PARITY: begin
        if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_nxt  = '0;
          par_bad_nxt  = ((^shift) != rx_sync);
          rx_err_c     = ((^shift) != rx_sync);
          rx_state_nxt = RX_STOP;
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
`endif
      RX_STOP: begin
        // After a bad stop bit, hold here until the line returns high
        if (stop_wait) begin
          if (rx_sync) rx_state_nxt = RX_IDLE;
        end else if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_nxt = '0;
          if (rx_sync) begin
`ifdef UART_LOADER_PARITY_EN
            byte_valid_c = !par_bad;
`else
            byte_valid_c = 1'b1;
`endif
            rx_state_nxt = RX_IDLE;
          end else begin
            rx_err_c      = 1'b1;
            stop_wait_nxt = 1'b1;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase

    // Packet assembler; a byte arriving on the timeout cycle is accepted
    case (pk_state)
      PK_B0: begin
        if (byte_valid_c) begin
          addr_hi_nxt  = shift;
          pk_state_nxt = PK_B1;
        end
      end
      PK_B1: begin
        if (byte_valid_c) begin
          mid_byte_nxt = shift;
          pk_state_nxt = PK_B2;
        end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_c    = 1'b1;
          pk_state_nxt = PK_B0;
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
      end
      PK_B2: begin
        if (byte_valid_c) begin
          write_en_nxt = 1'b1;
          addr_nxt     = {addr_hi, mid_byte[7:4]};
          datain_nxt   = N'({mid_byte[3:0], shift});
          pk_state_nxt = PK_WR;
        end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_c    = 1'b1;
          pk_state_nxt = PK_B0;
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
      end
      PK_WR: begin
        pk_state_nxt = PK_B0;
        if (word_count != 13'(WC_MAX)) word_count_nxt = word_count + 13'd1;
      end
      default: pk_state_nxt = PK_B0;
    endcase

    // A receive error drops any partial packet; a write already issued completes
    if (rx_err_c && (pk_state != PK_WR)) pk_state_nxt = PK_B0;

    frame_err_nxt = rx_err_c | timeout_c;
    busy_nxt      = (pk_state_nxt != PK_B0);
  end

endmodule

// File: tb/tb_uart_matrix_loader.sv
// Bench for uart_matrix_loader: drives UART frames, scoreboards expected writes.
module tb_uart_matrix_loader;

  localparam int unsigned N       = 17;
  localparam int unsigned CPB     = 8;
  localparam int unsigned TIMEOUT = 400;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rx = 1'b1;
  logic          write_en;
  logic [11:0]   addr;
  logic [N-1:0]  datain;
  logic          busy;
  logic          frame_err;
  logic [12:0]   word_count;

  typedef struct packed {
    logic [11:0]  a;
    logic [N-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   n_writes = 0;
  int   n_ferr = 0;
  int   exp_wc = 0;
  logic we_prev = 1'b0;
  logic fe_prev = 1'b0;

  uart_matrix_loader #(.N(N), .CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .rx(rx), .write_en(write_en), .addr(addr),
    .datain(datain), .busy(busy), .frame_err(frame_err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  // Monitor: pop scoreboard on every write, count frame errors, check pulse widths
  always @(negedge clk) begin
    exp_t e;
    if (write_en === 1'b1) begin
      n_writes++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write addr=%h datain=%h required none", addr, datain);
      end else begin
        e = exp_q.pop_front();
        if (addr !== e.a || datain !== e.d) begin
          miscompares++;
          $display("FAIL write_data addr=%h datain=%h required addr=%h datain=%h",
                   addr, datain, e.a, e.d);
        end
      end
      if (we_prev === 1'b1) begin
        vectors++;
        miscompares++;
        $display("FAIL write_en_width got 2+ cycles required 1");
      end
    end
    if (frame_err === 1'b1) begin
      n_ferr++;
      if (fe_prev === 1'b1) begin
        vectors++;
        miscompares++;
        $display("FAIL frame_err_width got 2+ cycles required 1");
      end
    end
    we_prev = write_en;
    fe_prev = frame_err;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input logic par_ok);
    rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(CPB);
    end
`ifdef UART_LOADER_PARITY_EN
    rx = (^b) ^ ~par_ok;
    cycles(CPB);
`else
    if (par_ok !== 1'b1) $display("note: parity flag ignored in 8N1 build");
`endif
    rx = stop_ok;
    cycles(CPB);
    rx = 1'b1;
  endtask

  task automatic send_packet(input logic [11:0] a, input logic [11:0] d);
    exp_t e;
    logic [7:0] b1;
    e.a = a;
    e.d = N'(d);
    exp_q.push_back(e);
    if (exp_wc < 4096) exp_wc++;
    b1 = {a[3:0], d[11:8]};
    send_byte(a[11:4], 1'b1, 1'b1);
    send_byte(b1, 1'b1, 1'b1);
    send_byte(d[7:0], 1'b1, 1'b1);
  endtask

  task automatic check_idle(input string tag, input int exp_writes, input int exp_ferr);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL %s_busy got %b required 0", tag, busy);
    end
    vectors++;
    if (word_count !== 13'(exp_wc)) begin
      miscompares++; $display("FAIL %s_word_count got %0d required %0d", tag, word_count, exp_wc);
    end
    vectors++;
    if (n_writes !== exp_writes) begin
      miscompares++; $display("FAIL %s_writes got %0d required %0d", tag, n_writes, exp_writes);
    end
    vectors++;
    if (n_ferr !== exp_ferr) begin
      miscompares++; $display("FAIL %s_frame_errs got %0d required %0d", tag, n_ferr, exp_ferr);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL %s_pending got %0d required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if ({write_en, addr, datain, busy, frame_err, word_count} !== '0) begin
      miscompares++;
      $display("FAIL %s we=%b addr=%h datain=%h busy=%b fe=%b wc=%0d required all 0",
               tag, write_en, addr, datain, busy, frame_err, word_count);
    end
  endtask

  task automatic test_reset;
    cycles(3);
    check_reset_outputs("reset_initial");
    reset_n = 1'b1;
    cycles(5);
    send_byte(8'h00, 1'b1, 1'b1);
    rx = 1'b0;               // byte 1 in progress
    cycles(20);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL reset_busy_mid got %b required 1", busy);
    end
    reset_n = 1'b0;
    cycles(1);
    check_reset_outputs("reset_mid_packet");
    rx = 1'b1;
    cycles(4);
    reset_n = 1'b1;
    cycles(100);
    check_idle("reset_after", 0, 0);
  endtask

  task automatic test_single;
    send_packet(12'h008, 12'h123);
    cycles(10);
    check_idle("single", 1, 0);
    vectors++;
    if (addr !== 12'h008 || datain !== 17'h00123) begin
      miscompares++; $display("FAIL single_hold addr=%h datain=%h required 008/00123", addr, datain);
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] a;
    for (int g = 0; g < 4; g++)
      for (int k = 0; k < 4; k++) begin
        a = 12'(8 + 64 * g + k);
        send_packet(a, 12'((k % 2) + 1));
      end
    cycles(10);
    check_idle("b2b", 17, 0);
  endtask

  task automatic test_glitch;
    rx = 1'b0;
    cycles(2);
    rx = 1'b1;
    cycles(30);
    check_idle("glitch", 17, 1);
  endtask

  task automatic test_stop_err;
    send_byte(8'h02, 1'b0, 1'b1);
    cycles(20);
    check_idle("stop_err", 17, 2);
    send_packet(12'h020, 12'h405);
    cycles(10);
    check_idle("stop_err_next", 18, 2);
  endtask

  task automatic test_timeout;
    send_byte(8'h20, 1'b1, 1'b1);
    send_byte(8'h40, 1'b1, 1'b1);
    cycles(5);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL timeout_busy_before got %b required 1", busy);
    end
    cycles(TIMEOUT + 10);
    check_idle("timeout", 18, 3);
    send_packet(12'h204, 12'h007);
    cycles(10);
    check_idle("timeout_next", 19, 3);
  endtask

  task automatic test_top_addr;
    send_packet(12'hFFE, 12'hABC);
    send_packet(12'hFF9, 12'h000);
    cycles(10);
    check_idle("top_addr", 21, 3);
    vectors++;
    if (datain !== 17'h00000 || addr !== 12'hFF9) begin
      miscompares++; $display("FAIL top_addr_hold addr=%h datain=%h required FF9/00000", addr, datain);
    end
  endtask

`ifdef UART_LOADER_PARITY_EN
  task automatic test_parity;
    send_byte(8'h81, 1'b1, 1'b0);
    cycles(20);
    check_idle("parity_bad", 21, 4);
    send_packet(12'h812, 12'h345);
    cycles(10);
    check_idle("parity_good", 22, 4);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_stop_err();
    test_timeout();
    test_top_addr();
`ifdef UART_LOADER_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
